// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the mem_sync_param scratch RAM.
// Holds the sweep FSM state type, the read-latency ceiling and the parity helper.
package mem_sync_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 4;

  // Even parity bit: the value that makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line for mem_sync_param: RD_LAT stages of {valid, data, parity flag}.
// Data and flag stages only load when a valid word arrives, so the output holds the last read.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_pe,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_pe
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] pe_q, pe_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  logic [RD_LAT-1:0] vld_c;
  logic [RD_LAT-1:0] pe_c;
  logic [DATA_W-1:0] dat_c [RD_LAT];

  always_comb begin
    vld_c[0] = in_vld;
    pe_c[0]  = in_pe;
    dat_c[0] = in_data;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_c[i] = vld_q[i-1];
      pe_c[i]  = pe_q[i-1];
      dat_c[i] = dat_q[i-1];
    end
    for (int i = 0; i < RD_LAT; i++) begin
      vld_d[i] = vld_c[i];
      pe_d[i]  = vld_c[i] ? pe_c[i]  : pe_q[i];
      dat_d[i] = vld_c[i] ? dat_c[i] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      pe_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      pe_q  <= pe_d;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_data = dat_q[RD_LAT-1];
  assign out_pe   = vld_q[RD_LAT-1] & pe_q[RD_LAT-1];

endmodule

// File: rtl/mem_sync_param.sv
// Parametrised single-port synchronous scratch RAM with pipelined reads and a clear sweep.
// Optional stored parity bit enabled by defining MEM_SYNC_PARITY_EN.
//
//   state    | meaning
//   ST_IDLE  | normal operation, ops accepted
//   ST_CLEAR | writing zero to word cnt_q each cycle, busy=1
module mem_sync_param
  import mem_sync_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_req,
  input  logic              par_inj,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT   = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
`ifdef MEM_SYNC_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              rd_pe;
  logic              wr_acc, rd_acc, any_req;

`ifdef MEM_SYNC_PARITY_EN
  assign wr_word = {even_par(64'(data_in)) ^ par_inj, data_in};
  assign rd_pe   = even_par(64'(rd_word[DATA_W-1:0])) ^ rd_word[DATA_W];
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign wr_word = data_in;
  assign rd_pe   = 1'b0;
`endif

  // Same-edge read-after-write never happens (one op per cycle), so an async
  // array read sampled into the pipe returns data written on the previous edge.
  assign rd_word = mem_q[addr];
  assign rd_data = rd_word[DATA_W-1:0];

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    any_req   = we | re;
    wr_acc    = en & ~busy & ~clr_req & we & ~re;
    rd_acc    = en & ~busy & ~clr_req & re & ~we;
    err_d     = en & ((we & re) | (busy & any_req) | (clr_req & any_req));
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wr_word;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (wr_acc) begin
          mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign err = err_q;

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_acc),
    .in_data  (rd_data),
    .in_pe    (rd_pe),
    .out_vld  (rd_valid),
    .out_data (data_out),
    .out_pe   (par_err)
  );

endmodule

// File: tb/tb_mem_sync_param.sv
// Self-checking bench for mem_sync_param (DATA_W=8, ADDR_W=4, RD_LAT=3).
// Directed scenarios plus a randomized run against a behavioural memory model.
module tb_mem_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;
`ifdef MEM_SYNC_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, we = 1'b0, re = 1'b0, clr_req = 1'b0, par_inj = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, busy, err, par_err;

  int checks = 0;
  int errors = 0;

  mem_sync_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .re(re), .addr(addr),
    .data_in(data_in), .clr_req(clr_req), .par_inj(par_inj),
    .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .err(err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array, pending-read list keyed by due cycle, sweep countdown.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    bit            known;
    bit            pe;
  } rd_t;

  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_bad   [DEPTH];
  rd_t           m_q[$];
  int            m_clr_left = 0;
  int            m_cyc = 0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_known = 1'b1;
  bit            exp_vld = 1'b0, exp_err = 1'b0, exp_busy = 1'b0, exp_pe = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_clr_left = 0;
    exp_data = '0; exp_known = 1'b1;
    exp_vld = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_pe = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 1'b0;
      m_bad[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit busy_pre;
    busy_pre = (m_clr_left > 0);
    m_cyc++;
    exp_err = en && ((we && re) || (busy_pre && (we || re)) || (clr_req && (we || re)));
    if (busy_pre) begin
      m_mem[DEPTH - m_clr_left]   = '0;
      m_known[DEPTH - m_clr_left] = 1'b1;
      m_bad[DEPTH - m_clr_left]   = 1'b0;
      m_clr_left--;
    end else if (clr_req) begin
      m_clr_left = DEPTH;
    end
    if (en && !busy_pre && !clr_req && (we != re)) begin
      if (we) begin
        m_mem[addr]   = data_in;
        m_known[addr] = 1'b1;
        m_bad[addr]   = par_inj;
      end else begin
        m_q.push_back('{m_cyc + LAT - 1, m_mem[addr], m_known[addr], m_bad[addr]});
      end
    end
    exp_vld = 1'b0;
    exp_pe  = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      rd_t r;
      r = m_q.pop_front();
      exp_vld   = 1'b1;
      exp_data  = r.d;
      exp_known = r.known;
      exp_pe    = PAR_ON && r.pe;
    end
    exp_busy = (m_clr_left > 0);
  endtask

  task automatic drive(input bit e, input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit c, input bit inj);
    en = e; we = w; re = r; addr = a; data_in = d; clr_req = c; par_inj = inj;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, '0, '0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %0h want 0", data_out); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %0b want 0", par_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    drive(1, 1, 0, 4'hF, 8'hA5, 0, 0); tick();
    drive(1, 0, 1, 4'hF, 8'h00, 0, 0); tick();
    drive(0, 0, 0, '0, '0, 0, 0);
    for (int j = 0; j < LAT; j++) begin
      if (j > 0) tick();
      checks++;
      if (rd_valid !== (j == LAT - 1)) begin
        errors++; $display("FAIL wr_rd_valid_lat%0d got %0b want %0b", j, rd_valid, (j == LAT - 1));
      end
    end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL wr_rd_data got %0h want a5", data_out); end
    tick();
    checks++; if (rd_valid !== 1'b0 || data_out !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_hold got vld=%0b data=%0h want vld=0 data=a5", rd_valid, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    bit            ev;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, AW'(i), vals[i], 0, 0); tick();
    end
    for (int off = 0; off < LAT + 3; off++) begin
      if (off < 3) drive(1, 0, 1, AW'(off), '0, 0, 0);
      else         drive(0, 0, 0, '0, '0, 0, 0);
      tick();
      ev = (off >= LAT - 1) && (off <= LAT + 1);
      checks++;
      if (rd_valid !== ev) begin errors++; $display("FAIL b2b_valid_off%0d got %0b want %0b", off, rd_valid, ev); end
      if (ev) begin
        checks++;
        if (data_out !== vals[off - LAT + 1]) begin
          errors++; $display("FAIL b2b_data_off%0d got %0h want %0h", off, data_out, vals[off - LAT + 1]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    drive(1, 1, 0, 4'h3, 8'h5A, 0, 0); tick();
    drive(1, 1, 1, 4'h3, 8'hC3, 0, 0); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %0b want 1", err); end
    drive(0, 1, 1, 4'h3, 8'hC3, 0, 0); tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got %0b want 0", err); end
    drive(0, 0, 0, '0, '0, 0, 0);
    for (int j = 0; j < LAT; j++) begin
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL illegal_rd_valid got %0b want 0", rd_valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL en0_err got %0b want 0", err); end
    end
    drive(1, 0, 1, 4'h3, '0, 0, 0); tick();
    drive(0, 0, 0, '0, '0, 0, 0);
    repeat (LAT - 1) tick();
    checks++; if (rd_valid !== 1'b1 || data_out !== 8'h5A) begin
      errors++; $display("FAIL illegal_unchanged got vld=%0b data=%0h want vld=1 data=5a", rd_valid, data_out);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, AW'(i), 8'hFF, 0, 0); tick();
    end
    drive(0, 0, 0, '0, '0, 1, 0); tick();
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (i == 1)      drive(1, 1, 0, 4'h5, 8'h77, 0, 0);
      else if (i == 2) drive(0, 0, 0, '0, '0, 1, 0);
      else             drive(0, 0, 0, '0, '0, 0, 0);
      tick();
      if (i == 1) begin
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_busy_write_err got %0b want 1", err); end
      end
      if (i == 2) begin
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_busy_clr_err got %0b want 0", err); end
      end
    end
    checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL clear_busy_cycles got %0d want %0d", busy_cnt, DEPTH); end
    for (int off = 0; off < DEPTH + LAT - 1; off++) begin
      if (off < DEPTH) drive(1, 0, 1, AW'(off), '0, 0, 0);
      else             drive(0, 0, 0, '0, '0, 0, 0);
      tick();
      if (off >= LAT - 1) begin
        checks++;
        if (rd_valid !== 1'b1 || data_out !== 8'h00) begin
          errors++; $display("FAIL clear_read_addr%0d got vld=%0b data=%0h want vld=1 data=0", off - LAT + 1, rd_valid, data_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive(0, 0, 0, '0, '0, 1, 0); tick();
    drive(0, 0, 0, '0, '0, 0, 0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0 || data_out !== '0 || par_err !== 1'b0) begin
      errors++; $display("FAIL rst_async got busy=%0b vld=%0b err=%0b data=%0h pe=%0b want all 0", busy, rd_valid, err, data_out, par_err);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got %0b want 0", busy); end
    drive(1, 1, 0, 4'h7, 8'h9C, 0, 0); tick();
    drive(1, 0, 1, 4'h7, '0, 0, 0); tick();
    drive(0, 0, 0, '0, '0, 0, 0);
    repeat (LAT - 1) tick();
    checks++; if (rd_valid !== 1'b1 || data_out !== 8'h9C) begin
      errors++; $display("FAIL rst_next_read got vld=%0b data=%0h want vld=1 data=9c", rd_valid, data_out);
    end
  endtask

  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 0, 4'h9, 8'h3C, 0, (k == 0)); tick();
      drive(1, 0, 1, 4'h9, '0, 0, 0); tick();
      drive(0, 0, 0, '0, '0, 0, 0);
      repeat (LAT - 1) tick();
      checks++;
      if (rd_valid !== 1'b1 || par_err !== (PAR_ON && (k == 0))) begin
        errors++; $display("FAIL parity_inj%0d got vld=%0b pe=%0b want vld=1 pe=%0b", (k == 0), rd_valid, par_err, (PAR_ON && (k == 0)));
      end
      tick();
      checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL parity_strobe got %0b want 0", par_err); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      drive(($urandom % 4) != 0, $urandom % 2, $urandom % 2, AW'($urandom),
            DW'($urandom), ($urandom % 90) == 0, ($urandom % 4) == 0);
      tick();
      checks++; if (rd_valid !== exp_vld) begin errors++; $display("FAIL rand_valid cyc%0d got %0b want %0b", n, rd_valid, exp_vld); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rand_err cyc%0d got %0b want %0b", n, err, exp_err); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc%0d got %0b want %0b", n, busy, exp_busy); end
      if (exp_known) begin
        checks++; if (data_out !== exp_data) begin errors++; $display("FAIL rand_data cyc%0d got %0h want %0h", n, data_out, exp_data); end
        checks++; if (par_err !== exp_pe) begin errors++; $display("FAIL rand_par cyc%0d got %0b want %0b", n, par_err, exp_pe); end
      end
    end
    drive(0, 0, 0, '0, '0, 0, 0);
    repeat (LAT + DEPTH) tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_clear();
    test_reset_mid_sweep();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
